// File: rtl/booth_seq_ctrl.sv
// ---------------------------------------------------------------------------
// booth_seq_ctrl
//
// Issue/sequencer stage in front of the 5x5 Booth multiplier. Operand pairs
// arrive on a valid/ready stream and are buffered in a small FIFO. One
// multiplication is in flight at a time: the head entry is popped into
// mul_m/mul_q, a single-cycle mul_start pulse is issued, and after a fixed
// latency the multiplier product is captured and offered on a valid/ready
// output stream.
//
// Ports
//   clk, rst            rising-edge clock, synchronous active-high reset
//   in_valid/in_ready   operand stream handshake (in_ready = FIFO not full)
//   in_m, in_q          multiplicand / multiplier, two's complement
//   mul_start           one-cycle start pulse to the multiplier
//   mul_m, mul_q        registered operands, held from one pop to the next
//   mul_result          product returned by the multiplier
//   out_valid/out_ready product stream handshake
//   out_data            captured product (passed through unmodified)
//   fifo_level          FIFO occupancy, 0..FIFO_DEPTH
//   busy                sequencer not idle
//   chk_err             sticky product-check error
//
// Optional feature: define BOOTH_SEQ_CHECK_EN to build a reference product
// that is compared against mul_result at capture time. Without the macro no
// reference logic exists and chk_err is tied low.
// ---------------------------------------------------------------------------
module booth_seq_ctrl #(
    parameter int DATA_W     = 5,
    parameter int RES_W      = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int RES_LAT    = 6
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [DATA_W-1:0]             in_m,
    input  logic [DATA_W-1:0]             in_q,
    output logic                          mul_start,
    output logic [DATA_W-1:0]             mul_m,
    output logic [DATA_W-1:0]             mul_q,
    input  logic [RES_W-1:0]              mul_result,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [RES_W-1:0]              out_data,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          busy,
    output logic                          chk_err
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int LAT_W = $clog2(RES_LAT + 1);

    localparam logic [CNT_W-1:0] FULL_LVL = CNT_W'(FIFO_DEPTH);
    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(RES_LAT - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_HOLD  = 2'd3;

    // FIFO storage (data only, never reset)
    logic [DATA_W-1:0] mem_m [FIFO_DEPTH];
    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q,  count_d;
    logic [1:0]        state_q,  state_d;
    logic [LAT_W-1:0]  lat_q,    lat_d;
    logic [DATA_W-1:0] mul_m_q,  mul_m_d;
    logic [DATA_W-1:0] mul_q_q,  mul_q_d;
    logic [RES_W-1:0]  out_data_q, out_data_d;
    logic              out_valid_q, out_valid_d;

    logic              push;
    logic              pop;
    logic              capture;
    logic [DATA_W-1:0] head_m;
    logic [DATA_W-1:0] head_q;

    assign head_m  = mem_m[rd_ptr_q];
    assign head_q  = mem_q[rd_ptr_q];

    assign in_ready   = (count_q != FULL_LVL);
    assign push       = in_valid && in_ready;
    // Pops only happen from IDLE, which is what keeps a single op in flight.
    assign pop        = (state_q == S_IDLE) && (count_q != '0);
    assign capture    = (state_q == S_WAIT) && (lat_q == LAT_LAST);

    assign mul_start  = (state_q == S_START);
    assign mul_m      = mul_m_q;
    assign mul_q      = mul_q_q;
    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign fifo_level = count_q;
    assign busy       = (state_q != S_IDLE);

    // FIFO pointer / level next-state
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        // Simultaneous push and pop cancel out in the level.
        if (push && !pop)      count_d = count_q + CNT_W'(1);
        else if (pop && !push) count_d = count_q - CNT_W'(1);
    end

    // Sequencer next-state
    always_comb begin
        state_d     = state_q;
        lat_d       = lat_q;
        mul_m_d     = mul_m_q;
        mul_q_d     = mul_q_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        case (state_q)
            S_IDLE: begin
                if (pop) begin
                    mul_m_d = head_m;
                    mul_q_d = head_q;
                    state_d = S_START;
                end
            end
            S_START: begin
                lat_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                lat_d = lat_q + LAT_W'(1);
                if (capture) begin
                    out_data_d  = mul_result;
                    out_valid_d = 1'b1;
                    state_d     = S_HOLD;
                end
            end
            default: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_m[wr_ptr_q] <= in_m;
            mem_q[wr_ptr_q] <= in_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            state_q     <= S_IDLE;
            lat_q       <= '0;
            mul_m_q     <= '0;
            mul_q_q     <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            state_q     <= state_d;
            lat_q       <= lat_d;
            mul_m_q     <= mul_m_d;
            mul_q_q     <= mul_q_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
        end
    end

`ifdef BOOTH_SEQ_CHECK_EN
    // Reference product is formed from the FIFO head at pop time, so it lines
    // up with the operands that mul_m/mul_q present for this op.
    logic signed [2*DATA_W-1:0] ref_prod;
    logic signed [2*DATA_W-1:0] ref_q;
    logic                       chk_err_q;

    assign ref_prod = $signed(head_m) * $signed(head_q);
    assign chk_err  = chk_err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            ref_q     <= '0;
            chk_err_q <= 1'b0;
        end else begin
            if (pop) ref_q <= ref_prod;
            if (capture && (ref_q[RES_W-1:0] != mul_result)) chk_err_q <= 1'b1;
        end
    end
`else
    assign chk_err = 1'b0;
`endif

endmodule

// File: tb/tb_booth_seq_ctrl.sv
module tb_booth_seq_ctrl;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [4:0] in_m;
    logic [4:0] in_q;
    logic       mul_start;
    logic [4:0] mul_m;
    logic [4:0] mul_q;
    logic [7:0] mul_result;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic [2:0] fifo_level;
    logic       busy;
    logic       chk_err;

    // Behavioural multiplier; 'bad' forces a wrong product.
    logic              bad;
    logic signed [9:0] prod;
    assign prod       = $signed(mul_m) * $signed(mul_q);
    assign mul_result = bad ? 8'h00 : prod[7:0];

    int passed = 0;
    int total  = 0;

`ifdef BOOTH_SEQ_CHECK_EN
    localparam logic CHK_EXP = 1'b1;
`else
    localparam logic CHK_EXP = 1'b0;
`endif

    booth_seq_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_m       (in_m),
        .in_q       (in_q),
        .mul_start  (mul_start),
        .mul_m      (mul_m),
        .mul_q      (mul_q),
        .mul_result (mul_result),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .fifo_level (fifo_level),
        .busy       (busy),
        .chk_err    (chk_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic push(input logic [4:0] m, input logic [4:0] q);
        in_valid = 1'b1;
        in_m     = m;
        in_q     = q;
        step();
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        for (int k = 0; k < 30 && !out_valid; k++) step();
        chk(tag, out_valid, 1'b1);
    endtask

    logic [7:0] exp3 [4];
    int         bad_cnt;
    int         starts;

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_m      = '0;
        in_q      = '0;
        out_ready = 1'b0;
        bad       = 1'b0;
        step();
        step();
        rst = 1'b0;

        // Reset state
        chk("rst_in_ready",  in_ready,   1'b1);
        chk("rst_busy",      busy,       1'b0);
        chk("rst_out_valid", out_valid,  1'b0);
        chk("rst_level",     fifo_level, 3'd0);
        chk("rst_start",     mul_start,  1'b0);
        chk("rst_chk_err",   chk_err,    1'b0);
        chk("rst_out_data",  out_data,   8'h00);
        chk("rst_mul_m",     mul_m,      5'h00);

        // 1: single op latency, push in cycle N
        push(5'd3, 5'd2);                             // now N+1
        chk("t1_level_n1", fifo_level, 3'd1);
        chk("t1_start_n1", mul_start,  1'b0);
        chk("t1_busy_n1",  busy,       1'b0);
        step();                                       // N+2
        chk("t1_start_n2", mul_start,  1'b1);
        chk("t1_busy_n2",  busy,       1'b1);
        chk("t1_mul_m",    mul_m,      5'd3);
        chk("t1_mul_q",    mul_q,      5'd2);
        chk("t1_level_n2", fifo_level, 3'd0);
        step();                                       // N+3
        chk("t1_start_n3", mul_start,  1'b0);
        for (int k = 0; k < 5; k++) step();           // N+8
        chk("t1_valid_n8", out_valid,  1'b0);
        step();                                       // N+9
        chk("t1_valid_n9", out_valid,  1'b1);
        chk("t1_data",     out_data,   8'h06);
        chk("t1_busy_n9",  busy,       1'b1);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("t1_valid_after_hs", out_valid, 1'b0);
        chk("t1_busy_after_hs",  busy,      1'b0);

        // 2: negative multiplicand, operands held throughout
        out_ready = 1'b1;
        push(5'h1D, 5'd5);                            // N+1
        step();                                       // N+2
        chk("t2_start", mul_start, 1'b1);
        bad_cnt = 0;
        for (int k = 0; k < 7; k++) begin
            if (mul_m !== 5'h1D || mul_q !== 5'd5) bad_cnt++;
            step();
        end                                           // N+9
        chk("t2_operands_stable", bad_cnt,   0);
        chk("t2_valid",           out_valid, 1'b1);
        chk("t2_data",            out_data,  8'hF1);
        chk("t2_mul_m_end",       mul_m,     5'h1D);
        step();
        out_ready = 1'b0;
        chk("t2_valid_after_hs", out_valid, 1'b0);

        // 3: fill FIFO while the sequencer sits in HOLD
        push(5'd2, 5'd3);
        wait_valid("t3_first_valid");
        chk("t3_first_data", out_data, 8'h06);
        exp3[0] = 8'h04;
        exp3[1] = 8'hF9;
        exp3[2] = 8'hE1;
        exp3[3] = 8'h00;
        push(5'd1,  5'd4);
        chk("t3_level1", fifo_level, 3'd1);
        push(5'h1F, 5'd7);
        chk("t3_level2", fifo_level, 3'd2);
        push(5'h0F, 5'h0F);
        chk("t3_level3", fifo_level, 3'd3);
        push(5'h10, 5'h10);
        chk("t3_level4",   fifo_level, 3'd4);
        chk("t3_full_rdy", in_ready,   1'b0);
        push(5'd3, 5'd3);                             // refused: FIFO full
        chk("t3_level_blocked", fifo_level, 3'd4);
        chk("t3_rdy_blocked",   in_ready,   1'b0);

        // 4: stall in HOLD for 20 cycles
        bad_cnt = 0;
        starts  = 0;
        for (int k = 0; k < 20; k++) begin
            step();
            if (out_valid !== 1'b1 || out_data !== 8'h06) bad_cnt++;
            if (mul_start) starts++;
        end
        chk("t4_hold_stable", bad_cnt, 0);
        chk("t4_no_start",    starts,  0);

        // 3 (cont.): drain in push order, start 2 cycles after each handshake
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("t3_no_start_h1", mul_start, 1'b0);
            step();
            chk("t3_start_h2", mul_start, 1'b1);
            wait_valid("t3_drain_valid");
            chk("t3_drain_data", out_data, {24'h0, exp3[i]});
        end
        step();
        step();
        chk("t3_final_start", mul_start,  1'b0);
        chk("t3_final_busy",  busy,       1'b0);
        chk("t3_final_level", fifo_level, 3'd0);
        out_ready = 1'b0;

        // 5: reset during WAIT with two entries queued
        in_valid = 1'b1;
        in_m = 5'd1; in_q = 5'd2;
        step();
        in_q = 5'd3;
        step();
        in_q = 5'd4;
        step();
        in_valid = 1'b0;
        chk("t5_level_pre", fifo_level, 3'd2);
        chk("t5_busy_pre",  busy,       1'b1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t5_level_post", fifo_level, 3'd0);
        chk("t5_valid_post", out_valid,  1'b0);
        chk("t5_busy_post",  busy,       1'b0);
        chk("t5_rdy_post",   in_ready,   1'b1);
        bad_cnt = 0;
        starts  = 0;
        for (int k = 0; k < 15; k++) begin
            step();
            if (out_valid) bad_cnt++;
            if (mul_start) starts++;
        end
        chk("t5_no_result", bad_cnt, 0);
        chk("t5_no_start",  starts,  0);
        push(5'd5, 5'd5);
        wait_valid("t5_new_valid");
        chk("t5_new_data", out_data, 8'h19);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;

        // 6: wrong product from the multiplier
        bad = 1'b1;
        push(5'd2, 5'd2);
        wait_valid("t6_valid");
        chk("t6_data_passthru", out_data, 8'h00);
        chk("t6_chk_err",       chk_err,  CHK_EXP);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        bad = 1'b0;
        for (int k = 0; k < 3; k++) step();
        chk("t6_chk_err_sticky", chk_err, CHK_EXP);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t6_chk_err_rst", chk_err, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/booth_seq_ctrl.md
Name: booth_seq_ctrl

Overview:
- Upstream issue/sequencer stage for the 5x5 Booth multiplier.
- Buffers operand pairs from a valid/ready stream in a small FIFO and drives one start pulse plus stable M/Q per operation.
- Waits a fixed result latency, captures the 8-bit product and presents it on a valid/ready output stream.
- Only one multiplication is in flight at any time.

Parameters:
DATA_W, 5, operand width (M and Q)
RES_W, 8, product width returned by the multiplier
FIFO_DEPTH, 4, operand FIFO entries; power of 2, >=2
RES_LAT, 6, cycles from the end of the start cycle to the result-sample cycle; >=1

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous, active-high reset
in_valid  in  1  operand pair valid
in_ready  out  1  FIFO can accept (= !full)
in_m  in  DATA_W  multiplicand, two's complement
in_q  in  DATA_W  multiplier, two's complement
mul_start  out  1  one-cycle start pulse to multiplier
mul_m  out  DATA_W  registered M, held from pop until next pop
mul_q  out  DATA_W  registered Q, held likewise
mul_result  in  RES_W  multiplier product
out_valid  out  1  product valid
out_ready  in  1  downstream accepts product
out_data  out  RES_W  captured product
fifo_level  out  clog2(FIFO_DEPTH)+1  current FIFO occupancy
busy  out  1  FSM not in IDLE
chk_err  out  1  sticky check error (see Optional Feature)

Behaviour:
- Reset (rst=1 at posedge) clears: FIFO pointers and count, FSM=IDLE, wait counter, mul_m/mul_q, out_data, mul_start, out_valid, chk_err. in_ready=1 and busy=0 after reset.
- Reset mid-operation drops the in-flight op and all buffered entries; no out_valid follows.
- FIFO push when in_valid&&in_ready. Pop happens only from IDLE.
- A push while full is impossible, because in_ready is low.
- Pointers wrap modulo FIFO_DEPTH. fifo_level counts 0..FIFO_DEPTH.
- A push and a pop in the same cycle leave the level unchanged.
- FSM states:
  - IDLE: if level!=0, pop the head into mul_m/mul_q and go to START; else stay.
  - START: mul_start=1 for exactly this cycle, clear counter, go to WAIT.
  - WAIT: counter increments each cycle. When counter==RES_LAT-1, register mul_result into out_data, set out_valid and go to HOLD.
  - HOLD: out_valid=1, out_data stable. On out_ready, clear out_valid and go to IDLE. With out_ready low, stay indefinitely; no new start is issued.
- Latency: operand accepted in cycle N with FSM idle and FIFO empty gives mul_start in N+2 and out_valid first high in N+RES_LAT+3 (default N+9).
- Back-to-back: after an out handshake in cycle H, the next mul_start comes in H+2 if the FIFO is non-empty.
- mul_m/mul_q do not change between pop and the next pop.
- Products are passed through unmodified. No arithmetic is performed on out_data.

Optional Feature:
- Macro: BOOTH_SEQ_CHECK_EN.
- Defined:
  - On pop, compute the signed product mul_m*mul_q (2*DATA_W bits) into a reference register.
  - At the capture cycle, compare its low RES_W bits with mul_result. On mismatch, set chk_err; it stays high until rst.
  - out_data still carries mul_result.
- Undefined: no reference logic is built and chk_err is tied 0.

Test Plan:
1. Reset, then push M=3, Q=2 in cycle N; model returns 8'h06 -> mul_start in N+2 only, out_valid in N+9, out_data=8'h06, busy high from N+2 until handshake.
2. Push M=-3 (5'h1D), Q=5 with out_ready=1 -> out_data=8'hF1. mul_m/mul_q stable for the whole op.
3. Push 5 pairs back-to-back with FSM held in HOLD (out_ready=0) -> fifo_level reaches 4, in_ready=0 on the 5th. Release out_ready -> 4 results in push order, each start 2 cycles after the previous handshake.
4. out_ready=0 for 20 cycles in HOLD -> out_valid and out_data constant, no mul_start pulses.
5. Assert rst during WAIT with 2 entries queued -> next cycle level=0, out_valid=0, no result ever emitted. A new push works normally afterward.
6. With BOOTH_SEQ_CHECK_EN, model returns 8'h00 for M=2, Q=2 -> chk_err=1 from the capture cycle on, held until rst. Without the macro, chk_err stays 0.
